// File: rtl/eco32_core_mpu_erx_pkg.sv
// Shared definitions for the MPU extended-register-file (erx) write path.
// Holds the serial write-bus geometry, the idle bus word, the arbiter
// state encoding and the helper that packs one write into a 9-byte frame.
package eco32_core_mpu_erx_pkg;

  localparam int ERX_FRAME_BEATS = 9;
  localparam int ERX_BUS_W       = 9;
  localparam int ERX_TAG_BIT     = 8;
  localparam int ERX_ADDR_W      = 4;
  localparam int ERX_DATA_W      = 64;
  localparam int ERX_FRAME_W     = ERX_FRAME_BEATS * 8;

  localparam logic [ERX_BUS_W-1:0] ERX_IDLE_WORD = 9'h000;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } erx_arb_state_e;

  // Frame layout, LSB byte goes out first:
  //   bytes 0..7 = data, byte 8 = {3'b000, tid, addr} (sent with the tag bit)
  function automatic logic [ERX_FRAME_W-1:0] erx_pack_frame(
    input logic                  tid,
    input logic [ERX_ADDR_W-1:0] addr,
    input logic [ERX_DATA_W-1:0] data
  );
    return {3'b000, tid, addr, data};
  endfunction

endpackage

// File: rtl/eco32_core_mpu_erx_wr_arb_if.sv
// One erx write requester channel.
//   stb  : request, held together with the payload until ack
//   ack  : payload captured this cycle (combinational from the arbiter)
//   tid  : thread id
//   addr : erx register index
//   data : 64-bit write data
// master = requester side, slave = arbiter side.
interface eco32_core_mpu_erx_wr_arb_if;
  import eco32_core_mpu_erx_pkg::*;

  logic                  stb;
  logic                  ack;
  logic                  tid;
  logic [ERX_ADDR_W-1:0] addr;
  logic [ERX_DATA_W-1:0] data;

  modport master (output stb, output tid, output addr, output data, input ack);
  modport slave  (input stb, input tid, input addr, input data, output ack);

endinterface

// File: rtl/eco32_core_mpu_erx_ser.sv
// Frame serialiser for the erx write bus.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture frame; beat 0 goes on wr_bus next cycle
//   adv      : a frame is in flight, step to the next beat
//   frame    : packed 72-bit frame (see erx_pack_frame)
//   wr_bus   : registered bus word, bit 8 = frame-end tag
//   last     : beat 8 (the tag beat) is on wr_bus this cycle
module eco32_core_mpu_erx_ser
  import eco32_core_mpu_erx_pkg::*;
#(
  parameter bit FORCE_RST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   adv,
  input  logic [ERX_FRAME_W-1:0] frame,
  output logic [ERX_BUS_W-1:0]   wr_bus,
  output logic                   last
);

  logic [3:0]               cnt_q;
  // Beats not yet on the bus; byte 0 always holds the next one to send.
  logic [ERX_FRAME_W-9:0]   sr_q;
  logic [ERX_FRAME_W-9:0]   sr_d;

  assign last = (cnt_q == 4'd8);

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = frame[ERX_FRAME_W-1:8];
    end else if (adv) begin
      sr_d = {8'h00, sr_q[ERX_FRAME_W-9:8]};
    end
  end

  // A new load wins over finishing the previous frame, so frames abut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      wr_bus <= ERX_IDLE_WORD;
    end else if (load) begin
      cnt_q  <= 4'd0;
      wr_bus <= {1'b0, frame[7:0]};
    end else if (adv) begin
      if (last) begin
        cnt_q  <= 4'd0;
        wr_bus <= ERX_IDLE_WORD;
      end else begin
        cnt_q  <= cnt_q + 4'd1;
        wr_bus <= {(cnt_q == 4'd7), sr_q[7:0]};
      end
    end
  end

  if (FORCE_RST) begin : g_sr_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end
  end else begin : g_sr
    always_ff @(posedge clk) begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/eco32_core_mpu_erx_wr_arb.sv
// Round-robin write arbiter for the erx 9-bit serial write bus.
// Two requesters (req0 = exception/trap unit, req1 = MSR write path) share
// the bus; one 64-bit write is captured per grant and sent as a 9-beat
// frame. A read-hazard compare flags {tid,addr} writes not yet visible at
// the erx read port.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req0, req1      : requester channels (slave side)
//   wr_bus          : serial erx write bus, bit 8 = frame-end tag
//   busy            : a frame beat is on wr_bus
//   hz_tid, hz_addr : read-side register to check
//   hz_hit          : a write to {hz_tid,hz_addr} is still in flight
module eco32_core_mpu_erx_wr_arb
  import eco32_core_mpu_erx_pkg::*;
#(
  parameter bit FORCE_RST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  eco32_core_mpu_erx_wr_arb_if.slave req0,
  eco32_core_mpu_erx_wr_arb_if.slave req1,
  output logic [ERX_BUS_W-1:0]  wr_bus,
  output logic                  busy,
  input  logic                  hz_tid,
  input  logic [ERX_ADDR_W-1:0] hz_addr,
  output logic                  hz_hit
);

  erx_arb_state_e          state_q;
  erx_arb_state_e          state_d;
  logic                    rr_q;      // 0: req0 wins a tie, 1: req1 wins
  logic                    ready;
  logic                    gnt0;
  logic                    gnt1;
  logic                    load;
  logic                    last;
  logic                    last_beat;

  logic                    cap_tid;
  logic [ERX_ADDR_W-1:0]   cap_addr;
  logic [ERX_DATA_W-1:0]   cap_data;
  logic [ERX_FRAME_W-1:0]  frame;

  // Entry A tracks the frame on the bus, entry B the erx write-tag stage.
  logic                    a_vld_q;
  logic                    a_tid_q;
  logic [ERX_ADDR_W-1:0]   a_addr_q;
  logic [1:0]              b_cnt_q;
  logic                    b_tid_q;
  logic [ERX_ADDR_W-1:0]   b_addr_q;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    // Capturing during the tag beat lets the next frame start without a gap.
    ready   = (state_q == ST_IDLE) || last_beat;
    if (ready) begin
      gnt0 = req0.stb && (!req1.stb || !rr_q);
      gnt1 = req1.stb && (!req0.stb ||  rr_q);
    end
    case (state_q)
      ST_IDLE:  if (gnt0 || gnt1) state_d = ST_SHIFT;
      ST_SHIFT: if (last_beat && !(gnt0 || gnt1)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt0) begin
        rr_q <= 1'b1;
      end else if (gnt1) begin
        rr_q <= 1'b0;
      end
    end
  end

  assign req0.ack  = gnt0;
  assign req1.ack  = gnt1;
  assign load      = gnt0 || gnt1;
  assign busy      = (state_q == ST_SHIFT);
  assign last_beat = busy && last;

  assign cap_tid  = gnt1 ? req1.tid  : req0.tid;
  assign cap_addr = gnt1 ? req1.addr : req0.addr;
  assign cap_data = gnt1 ? req1.data : req0.data;
  assign frame    = erx_pack_frame(cap_tid, cap_addr, cap_data);

  eco32_core_mpu_erx_ser #(
    .FORCE_RST (FORCE_RST)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .adv    (busy),
    .frame  (frame),
    .wr_bus (wr_bus),
    .last   (last)
  );

  // B stays valid for the two cycles after the tag beat (tag register stage
  // plus the erx write edge); A hands over to B as its frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld_q <= 1'b0;
      b_cnt_q <= 2'd0;
    end else begin
      if (load) begin
        a_vld_q <= 1'b1;
      end else if (last_beat) begin
        a_vld_q <= 1'b0;
      end
      if (last_beat) begin
        b_cnt_q <= 2'd2;
      end else if (b_cnt_q != 2'd0) begin
        b_cnt_q <= b_cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      a_tid_q  <= cap_tid;
      a_addr_q <= cap_addr;
    end
    if (last_beat) begin
      b_tid_q  <= a_tid_q;
      b_addr_q <= a_addr_q;
    end
  end

  assign hz_hit = (a_vld_q && ({a_tid_q, a_addr_q} == {hz_tid, hz_addr})) ||
                  ((b_cnt_q != 2'd0) && ({b_tid_q, b_addr_q} == {hz_tid, hz_addr}));

endmodule

// File: doc/eco32_core_mpu_erx_wr_arb.md
Name: eco32_core_mpu_erx_wr_arb

Overview:
- Shares the 9-bit serial write bus of the MPU extended register file (erx) between two requesters: req0 (exception/trap unit) and req1 (MSR write path).
- Arbitrates round-robin, captures one 64-bit write, and serialises it into a 9-byte frame.
- Exposes a read-hazard compare so the read port can stall while a write to the same {tid,addr} is still in flight.

Parameters:
- FORCE_RST, 0, 1: the frame shift register data also clears on reset. 0: only control state clears.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_stb  in  1  req0 write request; held with payload until ack
- req0_ack  out  1  req0 payload captured this cycle (combinational)
- req0_tid  in  1  req0 thread id
- req0_addr  in  4  req0 erx register index
- req0_data  in  64  req0 write data
- req1_stb, req1_ack, req1_tid, req1_addr, req1_data: same as req0, for req1
- wr_bus  out  9  serial erx write bus (registered); bit8 = frame-end tag, bits 7:0 = byte
- busy  out  1  a frame is being driven on wr_bus
- hz_tid  in  1  read-side thread id to check
- hz_addr  in  4  read-side register index to check
- hz_hit  out  1  a write to {hz_tid,hz_addr} is not yet visible at the erx read port

Behaviour:
- Reset values: wr_bus=0, busy=0, acks=0, hz_hit=0, rr pointer=req0, byte counter=0, pending entries invalid.
- Frame format: 9 consecutive wr_bus beats, one per cycle.
  - Beats 0..7: {1'b0, data[8k+7:8k]}, k=0..7, LSB byte first.
  - Beat 8: {1'b1, 3'b000, tid, addr}.
  - Idle beat: 9'h000.
- Capture window ("ready"): state IDLE, or state SHIFT with counter==8 (last beat on the bus). This gives back-to-back frames with no idle beat.
- Arbitration: when ready, pick among asserted stb.
  - Both asserted: grant the requester indicated by the rr pointer; the pointer then flips to the other requester.
  - One asserted: grant it; the pointer moves to the other requester.
- ackN is high combinationally in the capture cycle only. At most one ack per cycle. Payload is latched at that edge.
- Latency: beat 0 appears on wr_bus the cycle after ack. Beat 8 appears at ack+9.
- FSM:
  - IDLE -> SHIFT on grant (counter<=0).
  - SHIFT: counter increments each cycle.
  - At counter==8: on a new grant, stay in SHIFT with counter<=0; otherwise go to IDLE (wr_bus<=0).
- busy=1 exactly while a frame beat is on wr_bus.
- Hazard tracking:
  - Entry A: {tid,addr} of the frame being shifted, valid from capture edge through the beat-8 cycle.
  - Entry B: receives A at the end of the beat-8 cycle and stays valid 2 further cycles. This covers the erx write-tag register stage and the write edge.
  - hz_hit = (A.vld & A match) | (B.vld & B match), combinational.
  - A and B may both be valid during back-to-back frames.
- Reset mid-frame: wr_bus drops to 0 immediately (async). No tag beat is emitted, so erx performs no write. Pending entries clear. The captured request is lost; requesters must not re-issue after rst.
- Protocol rule (bench assertion): stb must not deassert, and payload must not change, while stb=1 and ack=0.

Decomposition:
- Package eco32_core_mpu_erx_pkg holds:
  - ERX_FRAME_BEATS=9, ERX_BUS_W=9, ERX_TAG_BIT=8, ERX_ADDR_W=4, ERX_DATA_W=64.
  - Idle word 9'h000.
  - Frame packing function {tid,addr,data} -> 72-bit frame.
- Sub-module eco32_core_mpu_erx_ser: 72-bit shift register plus 0..8 beat counter with load/shift/last outputs. Arbiter, FSM glue and hazard entries stay in the top module.

Test Plan:
- Single write: req0 tid0 addr3 data 64'h0123456789ABCDEF.
  - Required: ack0 one cycle.
  - wr_bus beats 0EF,0CD,0AB,089,067,045,023,001,103, then 000.
  - erx model entry {0,3} holds the data 2 cycles after beat 8.
- Simultaneous stb after reset: req0 (tid1 addr5), req1 (tid0 addr9).
  - Required: req0 granted first; ack1 is asserted in req0's beat-8 cycle.
  - Frames abut: beat 8 = 115 then beat 8 = 109, with no 000 between them.
- Both stb held continuously for 4 frames -> grant order 0,1,0,1; busy stays high for 36 cycles.
- Hazard: req1 write tid1 addr2; query {1,2} each cycle.
  - Required: hz_hit=1 from the ack+1 cycle through 2 cycles after beat 8, then 0.
  - Query {0,2} -> 0 throughout.
- Reset pulse at beat 4 of a frame -> wr_bus=000 immediately, no tag beat, hz_hit=0, erx contents unchanged; the next request after rst is granted cleanly.
